// File: rtl/hs_fifo_responder.sv
// hs_fifo_responder: responder end of a req/ack handshake. It serves words
// from an internal circular FIFO that is filled through a simple write port.
// Each served word produces a one-cycle ack. Acks are never back to back.
// Optional feature: define HS_RESP_STALL_CNT_EN to add the stall_count output.
// stall_count counts cycles where req is high, no ack is pending and the FIFO is empty.
module hs_fifo_responder #(
  parameter int unsigned responder_id = 0,
  parameter int unsigned data_width   = 32,
  parameter int unsigned depth_log2   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  output logic                  wr_full,
  output logic                  overflow,
  output logic [depth_log2:0]   level,
  input  logic                  req,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  output logic [31:0]           count
`ifdef HS_RESP_STALL_CNT_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  localparam int unsigned AW    = depth_log2;
  localparam int unsigned PW    = depth_log2 + 1;
  localparam int unsigned DEPTH = 1 << depth_log2;

  // responder_id is an informational tag only; it has no effect on the logic
  if (responder_id != 0) begin : g_tagged
  end

  logic [data_width-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic                  ack_q, ack_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [31:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
`ifdef HS_RESP_STALL_CNT_EN
  logic [31:0]           stall_q, stall_d;
`endif

  logic empty_c, full_c, push_c, pop_c;

  // Pointer flags, push/serve decisions and next-state values
  always_comb begin
    empty_c    = (rd_q == wr_q);
    full_c     = (rd_q[AW-1:0] == wr_q[AW-1:0]) && (rd_q[AW] != wr_q[AW]);
    push_c     = wr_en & ~full_c;
    pop_c      = req & ~ack_q & ~empty_c;

    wr_d       = wr_q;
    rd_d       = rd_q;
    ack_d      = 1'b0;
    dout_d     = dout_q;
    count_d    = count_q;
    overflow_d = overflow_q;
`ifdef HS_RESP_STALL_CNT_EN
    stall_d    = stall_q;
`endif

    if (push_c) wr_d = wr_q + PW'(1);
    if (wr_en && full_c) overflow_d = 1'b1;

    // Serve at most one word, and never in the cycle right after an ack
    if (pop_c) begin
      ack_d   = 1'b1;
      dout_d  = mem_q[rd_q[AW-1:0]];
      rd_d    = rd_q + PW'(1);
      count_d = count_q + 32'd1;
    end

`ifdef HS_RESP_STALL_CNT_EN
    if (req && !ack_q && empty_c) stall_d = stall_q + 32'd1;
`endif
  end

  // Control state with synchronous reset; a pending ack and queued data are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      ack_q      <= 1'b0;
      dout_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef HS_RESP_STALL_CNT_EN
      stall_q    <= '0;
`endif
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef HS_RESP_STALL_CNT_EN
      stall_q    <= stall_d;
`endif
    end
  end

  // FIFO storage; contents are not reset, only the pointers are
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem_q[wr_q[AW-1:0]] <= wr_data;
  end

  assign wr_full  = full_c;
  assign level    = wr_q - rd_q;
  assign overflow = overflow_q;
  assign ack      = ack_q;
  assign dout     = dout_q;
  assign count    = count_q;
`ifdef HS_RESP_STALL_CNT_EN
  assign stall_count = stall_q;
`endif

endmodule
